// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;
  localparam logic [3:0] BCD_NINE   = 4'h9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
import bcd_pkg::*;

module bcd_digit_adj (
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adj
);

  // 4-bit wrap is intentional: a digit above 9 only occurs after overflow.
  always_comb begin
    adj = (digit >= ADJ_THRESH) ? digit + ADJ_ADD : digit;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one binary bit per clock.
// Saturates to all nines on overflow and produces a leading-zero blank mask
// for the seven-segment driver.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | adjusting and shifting one operand bit per cycle
import bcd_pkg::*;

module bin_to_bcd_seq #(
  parameter int BIN_W  = 28,
  parameter int DIGITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                      overflow,
  output logic [DIGITS-1:0]         lead_blank
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = DIGIT_W * DIGITS;

  state_t             state;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   work;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_flag;

  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   work_next;
  logic               carry_out;
  logic               ovf_next;
  logic               last_iter;
  logic [BCD_W-1:0]   final_bcd;
  logic [DIGITS-1:0]  blank_next;
  logic               all_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (work[g*DIGIT_W +: DIGIT_W]),
      .adj   (work_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // One iteration of shift-and-add-3; the bit leaving the top digit means
  // the operand no longer fits in DIGITS decimal digits.
  always_comb begin
    {carry_out, work_next} = {work_adj, bin_reg[BIN_W-1]};
    ovf_next  = ovf_flag | carry_out;
    last_iter = (cnt == CNT_W'(BIN_W - 1));
    final_bcd = ovf_next ? {DIGITS{BCD_NINE}} : work_next;
  end

  // Blank digit i when it and every more significant digit are zero; the
  // units digit is always shown.
  always_comb begin
    blank_next = '0;
    all_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero      = all_zero & (final_bcd[i*DIGIT_W +: DIGIT_W] == '0);
      blank_next[i] = all_zero;
    end
    blank_next[0] = 1'b0;
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bin_reg    <= '0;
      work       <= '0;
      cnt        <= '0;
      ovf_flag   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      overflow   <= 1'b0;
      lead_blank <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_reg  <= bin;
            work     <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bin_reg  <= {bin_reg[BIN_W-2:0], 1'b0};
          work     <= work_next;
          ovf_flag <= ovf_next;
          cnt      <= cnt + 1'b1;
          if (last_iter) begin
            bcd        <= final_bcd;
            overflow   <= ovf_next;
            lead_blank <= blank_next;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 28-bit/8-digit instance plus two
// 8-bit instances (3 and 2 digits). Expected results come from decimal
// arithmetic on the operand.
module tb_bin_to_bcd_seq;

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    logic [7:0]  lb;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [27:0] bin = '0;
  logic        busy, done, overflow;
  logic [31:0] bcd;
  logic [7:0]  lead_blank;

  logic        s_start = 1'b0;
  logic [7:0]  s_bin = '0;
  logic        busy3, done3, ovf3, busy2, done2, ovf2;
  logic [11:0] bcd3;
  logic [2:0]  lb3;
  logic [7:0]  bcd2;
  logic [1:0]  lb2;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  exp_t q[$];
  exp_t q3[$];
  exp_t q2[$];
  exp_t em, e3, e2;
  logic [40:0] hold = '0;
  logic        prev_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.BIN_W(28), .DIGITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin), .busy(busy), .done(done),
    .bcd(bcd), .overflow(overflow), .lead_blank(lead_blank)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .start(s_start), .bin(s_bin), .busy(busy3), .done(done3),
    .bcd(bcd3), .overflow(ovf3), .lead_blank(lb3)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(s_start), .bin(s_bin), .busy(busy2), .done(done2),
    .bcd(bcd2), .overflow(ovf2), .lead_blank(lb2)
  );

  function automatic exp_t model(longint v, int digits);
    exp_t   e;
    longint r   = v;
    longint lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    e.bcd = '0;
    e.lb  = '0;
    e.t   = 0;
    e.ovf = (v >= lim);
    for (int i = 0; i < digits; i++) begin
      if (e.ovf) e.bcd[i*4 +: 4] = 4'h9;
      else begin
        e.bcd[i*4 +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end
    for (int i = 1; i < digits; i++) e.lb[i] = ((e.bcd >> (4 * i)) == 0);
    return e;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic flag_fail(string name);
    n_chk++;
    $display("FAIL %s: got event expected none (t=%0t)", name, $time);
  endtask

  // Main-instance monitor: pops an expectation on every done pulse.
  always @(negedge clk) begin
    if (done) begin
      check("done_busy_low", busy, 0);
      if (prev_done) flag_fail("done_consecutive");
      if (q.size() == 0) flag_fail("unexpected_done");
      else begin
        em = q.pop_front();
        check("bcd", bcd, em.bcd);
        check("overflow", overflow, em.ovf);
        check("lead_blank", lead_blank, em.lb);
        check("latency", cyc - em.t, 29);
        hold = {em.ovf, em.lb, em.bcd};
      end
    end else begin
      check("hold_outputs", {overflow, lead_blank, bcd}, hold);
    end
    prev_done = done;
  end

  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) flag_fail("unexpected_done3");
      else begin
        e3 = q3.pop_front();
        check("bcd3", {ovf3, lb3, bcd3}, {e3.ovf, e3.lb[2:0], e3.bcd[11:0]});
        check("latency3", cyc - e3.t, 9);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) flag_fail("unexpected_done2");
      else begin
        e2 = q2.pop_front();
        check("bcd2", {ovf2, lb2, bcd2}, {e2.ovf, e2.lb[1:0], e2.bcd[7:0]});
        check("latency2", cyc - e2.t, 9);
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (!busy) return;
      @(negedge clk);
    end
    flag_fail("timeout_idle");
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) return;
    end
    flag_fail("timeout_done");
  endtask

  task automatic push_main(logic [27:0] v);
    exp_t e;
    e   = model(longint'(v), 8);
    e.t = cyc;
    q.push_back(e);
  endtask

  task automatic issue(logic [27:0] v);
    wait_idle();
    start = 1'b1;
    bin   = v;
    push_main(v);
    @(negedge clk);
    start = 1'b0;
    bin   = 28'($urandom);
  endtask

  task automatic issue_small(logic [7:0] v);
    exp_t e;
    for (int k = 0; k < 40 && (busy3 || busy2); k++) @(negedge clk);
    s_start = 1'b1;
    s_bin   = v;
    e = model(longint'(v), 3); e.t = cyc; q3.push_back(e);
    e = model(longint'(v), 2); e.t = cyc; q2.push_back(e);
    @(negedge clk);
    s_start = 1'b0;
    s_bin   = 8'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (q.size() + q3.size() + q2.size()) != 0; k++) @(negedge clk);
    if ((q.size() + q3.size() + q2.size()) != 0) flag_fail("timeout_drain");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_state", {busy, done, overflow, lead_blank, bcd}, 0);
    check("reset_small", {busy3, done3, ovf3, lb3, bcd3, busy2, done2, ovf2, lb2, bcd2}, 0);

    issue(28'd99_999_999);
    issue(28'd0);
    issue(28'd1_234);
    issue(28'hFFF_FFFF);
    issue(28'd100_000_000);
    issue(28'd10_000_000);
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) issue(28'($urandom_range(0, 9_999)));
      else issue(28'($urandom));
    end
    drain();

    // Start held high across three back-to-back conversions.
    wait_idle();
    start = 1'b1;
    bin   = 28'd5;
    push_main(28'd5);
    @(negedge clk);
    bin = 28'($urandom);
    wait_done();
    bin = 28'd10;
    push_main(28'd10);
    @(negedge clk);
    bin = 28'($urandom);
    wait_done();
    bin = 28'd100_000;
    push_main(28'd100_000);
    @(negedge clk);
    bin = 28'($urandom);
    wait_done();
    start = 1'b0;
    drain();

    // Start pulse during a conversion must be ignored.
    issue(28'd777);
    repeat (5) @(negedge clk);
    start = 1'b1;
    bin   = 28'd31_337;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (30) @(negedge clk);

    // Reset partway through a conversion aborts it.
    issue(28'd55_555_555);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    hold = '0;
    @(negedge clk);
    check("abort_state", {busy, done, overflow, lead_blank, bcd}, 0);
    repeat (35) @(negedge clk);
    issue(28'h42);
    drain();

    // Narrow instances.
    issue_small(8'd255);
    issue_small(8'd100);
    issue_small(8'd99);
    issue_small(8'd0);
    for (int i = 0; i < 15; i++) issue_small(8'($urandom));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
